// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu shared types
// funct3 encodings, FSM states, legality check
package data_mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_DATA,
    RMW_MERGE
  } state_t;

  // 1 when the access is misaligned or the funct3 is not legal
  function automatic logic req_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lo[0];
      F3_W:    bad = |lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu bus bundles
// core request/response side and word-memory side
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

interface data_mem_bus_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  mem_we;
  logic [3:0]            mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_we, mem_wmask,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_wmask,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_lsu_byte_lane.sv
// lsu_byte_lane: byte-lane steering
// load extract/extend and store merge/mask
module lsu_byte_lane
  import data_mem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  store_mask
);

  logic [31:0] sh;
  logic [31:0] rep;

  assign sh = word >> {lane, 3'b000};

  // pick the addressed lane and extend it
  always_comb begin
    load_data = word;
    unique case (1'b1)
      funct3 == F3_B:  load_data = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_BU: load_data = {24'h0, sh[7:0]};
      funct3 == F3_H:  load_data = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_HU: load_data = {16'h0, sh[15:0]};
      default:         load_data = word;
    endcase
  end

  // replicate store data, enable the lanes, merge over old word
  always_comb begin
    rep        = wdata;
    store_mask = 4'hF;
    unique case (1'b1)
      funct3 == F3_B: begin
        rep        = {4{wdata[7:0]}};
        store_mask = 4'b0001 << lane;
      end
      funct3 == F3_H: begin
        rep        = {2{wdata[15:0]}};
        store_mask = 4'b0011 << lane;
      end
      default: begin
        rep        = wdata;
        store_mask = 4'hF;
      end
    endcase
    store_word = '0;
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = store_mask[i] ?
        rep[8*i +: 8] : word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32I load/store unit
// drives a 1-cycle registered-read word memory
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input logic            clk,
  input logic            rst,
  data_mem_lsu_if.slave  core,
  data_mem_bus_if.master mem
);

  localparam int AB = ADDR_WIDTH + 2;

  state_t state;
  state_t next_state;

  logic          h_we;
  logic [2:0]    h_f3;
  logic [AB-1:0] h_addr;
  logic [31:0]   h_wdata;

  logic          idle;
  logic          accept;
  logic          bad;
  logic [2:0]    s_f3;
  logic [AB-1:0] s_addr;
  logic [31:0]   s_wdata;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic [3:0]  st_mask;

  logic        we_d;
  logic        resp_d;
  logic        err_d;
  logic [31:0] rdata_d;

  logic        resp_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic unused_addr;
  assign unused_addr = ^core.req_addr[31:AB];

  assign idle   = (state == IDLE);
  assign accept = core.req_valid && idle;
  assign bad    = req_bad(core.req_we, core.req_funct3,
                          core.req_addr[1:0]);

  assign s_f3    = idle ? core.req_funct3 : h_f3;
  assign s_addr  = idle ? core.req_addr[AB-1:0] : h_addr;
  assign s_wdata = idle ? core.req_wdata : h_wdata;

  lsu_byte_lane u_lane (
    .word       (mem.mem_rdata),
    .wdata      (s_wdata),
    .lane       (s_addr[1:0]),
    .funct3     (s_f3),
    .load_data  (ld_data),
    .store_word (st_word),
    .store_mask (st_mask)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next state: loads and sub-word stores take a second cycle
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept && !bad) begin
          if (!core.req_we)
            next_state = LOAD_DATA;
          else if (core.req_funct3 != F3_W)
            next_state = RMW_MERGE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // memory strobe and next response per state
  always_comb begin
    we_d    = 1'b0;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            resp_d = 1'b1;
            err_d  = 1'b1;
          end else if (core.req_we &&
                       core.req_funct3 == F3_W) begin
            we_d   = 1'b1;
            resp_d = 1'b1;
          end
        end
      end
      LOAD_DATA: begin
        resp_d  = 1'b1;
        rdata_d = ld_data;
      end
      RMW_MERGE: begin
        we_d   = 1'b1;
        resp_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.mem_we    = we_d && !rst;
  assign mem.mem_wmask = st_mask;
  assign mem.mem_addr  = s_addr[AB-1:2];
  assign mem.mem_wdata = st_word;

  assign core.req_ready  = idle;
  assign core.resp_valid = resp_q;
  assign core.resp_err   = err_q;
  assign core.resp_rdata = rdata_q;

  // response register: one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // hold the accepted request for the second cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      h_we    <= 1'b0;
      h_f3    <= '0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else if (accept) begin
      h_we    <= core.req_we;
      h_f3    <= core.req_funct3;
      h_addr  <= core.req_addr[AB-1:0];
      h_wdata <= core.req_wdata;
    end
  end

  logic unused_we;
  assign unused_we = h_we;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: byte-level reference model
// plus directed vectors with literal expectations
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;

  localparam int AW = 13;
  localparam int NB = 4 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   pre = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt = 0;

  always #5 clk = ~clk;

  data_mem_lsu_if core();
  data_mem_bus_if #(.ADDR_WIDTH(AW)) mem();

  data_mem_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .mem  (mem)
  );

  logic [31:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
      ram[16] <= 32'h8899AABB;
    end else if (mem.mem_we) begin
      ram[mem.mem_addr] <= mem.mem_wdata;
    end
    mem.mem_rdata <= ram[mem.mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mem.mem_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    bit          err;
    bit          st;
    bit          two;
    bit          rmw;
    int          a;
    int          n;
    logic [31:0] rd;
    logic [31:0] wd;
  } ent_t;

  logic [7:0] mb [0:NB-1];
  ent_t q[$];

  function automatic ent_t build(input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr,
                                 input logic [31:0] wd);
    ent_t e;
    logic [31:0] v;
    e.a  = int'(addr[AW+1:0]);
    e.n  = (f3 == 3'd0 || f3 == 3'd4) ? 1 :
           (f3 == 3'd1 || f3 == 3'd5) ? 2 :
           (f3 == 3'd2) ? 4 : 0;
    e.st  = we;
    e.err = (e.n == 0) || (we && f3[2]);
    if (!e.err && (e.a % e.n) != 0) e.err = 1'b1;
    e.two = !e.err && (!we || e.n < 4);
    e.rmw = !e.err && we && e.n < 4;
    e.wd  = wd;
    e.rd  = '0;
    e.due = 0;
    if (!e.err && !we) begin
      v = '0;
      for (int i = 0; i < e.n; i++) v[8*i +: 8] = mb[e.a + i];
      if (!f3[2] && e.n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && e.n == 2) v = {{16{v[15]}}, v[15:0]};
      e.rd = v;
    end
    return e;
  endfunction

  function automatic logic [31:0] merged(input ent_t e);
    logic [31:0] w;
    int b;
    b = e.a & ~3;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mb[b + i];
    for (int i = 0; i < e.n; i++)
      w[8*((e.a - b) + i) +: 8] = e.wd[8*i +: 8];
    return w;
  endfunction

  initial begin
    ent_t e;
    bit rdy;
    bit ewe;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (pre) begin
        for (int i = 0; i < NB; i++) mb[i] = '0;
        mb[64] = 8'hBB; mb[65] = 8'hAA;
        mb[66] = 8'h99; mb[67] = 8'h88;
        q.delete();
      end else if (rst) begin
        chk("m_rst_we", {31'h0, mem.mem_we}, 32'h0);
        q.delete();
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("m_rv", {31'h0, core.resp_valid}, 32'h1);
          chk("m_err", {31'h0, core.resp_err}, {31'h0, e.err});
          chk("m_rdata", core.resp_rdata, e.rd);
          if (e.st && !e.err)
            for (int i = 0; i < e.n; i++)
              mb[e.a + i] = e.wd[8*i +: 8];
        end else begin
          chk("m_rv_idle", {31'h0, core.resp_valid}, 32'h0);
        end
        rdy = !(q.size() > 0 && q[0].two && q[0].due == cyc + 1);
        chk("m_ready", {31'h0, core.req_ready}, {31'h0, rdy});
        ewe = 1'b0;
        ea  = '0;
        ed  = '0;
        if (q.size() > 0 && q[0].rmw && q[0].due == cyc + 1) begin
          ewe = 1'b1;
          ea  = AW'(q[0].a >> 2);
          ed  = merged(q[0]);
        end
        if (core.req_valid && rdy) begin
          e = build(core.req_we, core.req_funct3,
                    core.req_addr, core.req_wdata);
          e.due = cyc + (e.two ? 2 : 1);
          q.push_back(e);
          if (e.st && !e.err && !e.two) begin
            ewe = 1'b1;
            ea  = AW'(e.a >> 2);
            ed  = e.wd;
          end
        end
        chk("m_we", {31'h0, mem.mem_we}, {31'h0, ewe});
        if (ewe) begin
          chk("m_waddr", {19'h0, mem.mem_addr}, {19'h0, ea});
          chk("m_wdata", mem.mem_wdata, ed);
        end
      end
    end
  end

  task automatic drive(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    core.req_valid  = 1'b1;
    core.req_we     = we;
    core.req_funct3 = f3;
    core.req_addr   = a;
    core.req_wdata  = wd;
  endtask

  task automatic txn(input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int lat, input bit err,
                     input logic [31:0] rd, input string nm);
    int c0;
    bit got;
    @(posedge clk); #1;
    drive(we, f3, a, wd);
    c0 = cyc;
    @(posedge clk); #1;
    core.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (core.resp_valid) begin
        got = 1'b1;
        chk({nm, "_lat"}, cyc - c0, lat);
        chk({nm, "_err"}, {31'h0, core.resp_err}, {31'h0, err});
        chk({nm, "_rdata"}, core.resp_rdata, rd);
      end
    end
    if (!got) chk({nm, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int w0;
    core.req_valid  = 1'b0;
    core.req_we     = 1'b0;
    core.req_funct3 = '0;
    core.req_addr   = '0;
    core.req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1 pre = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rv", {31'h0, core.resp_valid}, 32'h0);
    chk("rst_err", {31'h0, core.resp_err}, 32'h0);
    chk("rst_rdata", core.resp_rdata, 32'h0);
    chk("rst_we", {31'h0, mem.mem_we}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, core.req_ready}, 32'h1);

    txn(0, F3_W,  32'h40,   0, 2, 0, 32'h8899AABB, "lw40");
    txn(0, F3_B,  32'h43,   0, 2, 0, 32'hFFFFFF88, "lb43");
    txn(0, F3_BU, 32'h43,   0, 2, 0, 32'h00000088, "lbu43");
    txn(0, F3_H,  32'h42,   0, 2, 0, 32'hFFFF8899, "lh42");
    txn(0, F3_HU, 32'h40,   0, 2, 0, 32'h0000AABB, "lhu40");
    txn(0, F3_H,  32'h40,   0, 2, 0, 32'hFFFFAABB, "lh40");
    txn(0, F3_W,  32'h8040, 0, 2, 0, 32'h8899AABB, "lwwrap");

    @(posedge clk); #1;
    drive(1, F3_B, 32'h41, 32'h123456CC);
    @(negedge clk);
    chk("sb_c0_we", {31'h0, mem.mem_we}, 32'h0);
    @(posedge clk); #1 core.req_valid = 1'b0;
    @(negedge clk);
    chk("sb_c1_we", {31'h0, mem.mem_we}, 32'h1);
    chk("sb_c1_mask", {28'h0, mem.mem_wmask}, 32'h2);
    chk("sb_c1_wdata", mem.mem_wdata, 32'h8899CCBB);
    chk("sb_c1_rv", {31'h0, core.resp_valid}, 32'h0);
    @(negedge clk);
    chk("sb_c2_rv", {31'h0, core.resp_valid}, 32'h1);
    chk("sb_c2_err", {31'h0, core.resp_err}, 32'h0);
    txn(0, F3_W, 32'h40, 0, 2, 0, 32'h8899CCBB, "lw_after_sb");

    w0 = we_cnt;
    txn(1, F3_H,   32'h43, 32'h5555, 1, 1, 32'h0, "sh43_err");
    txn(0, F3_W,   32'h42, 0,        1, 1, 32'h0, "lw42_err");
    txn(0, 3'b011, 32'h40, 0,        1, 1, 32'h0, "ld011_err");
    txn(1, F3_BU,  32'h40, 32'h77,   1, 1, 32'h0, "st100_err");
    @(negedge clk);
    chk("err_no_we", we_cnt, w0);

    @(posedge clk); #1;
    drive(1, F3_W, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(0, F3_W, 32'h40, 0);
    @(negedge clk);
    chk("sw_rv", {31'h0, core.resp_valid}, 32'h1);
    chk("sw_rdata", core.resp_rdata, 32'h0);
    @(posedge clk); #1 core.req_valid = 1'b0;
    @(negedge clk);
    chk("raw_c2_rv", {31'h0, core.resp_valid}, 32'h0);
    @(negedge clk);
    chk("raw_c3_rv", {31'h0, core.resp_valid}, 32'h1);
    chk("raw_c3_rdata", core.resp_rdata, 32'hDEADBEEF);

    @(posedge clk); #1;
    drive(1, F3_B, 32'h40, 32'h11);
    @(posedge clk); #1;
    core.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_we", {31'h0, mem.mem_we}, 32'h0);
    chk("rstmid_rv", {31'h0, core.resp_valid}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'h0, core.req_ready}, 32'h1);
    chk("rstmid_rv2", {31'h0, core.resp_valid}, 32'h0);
    @(negedge clk);
    chk("rstmid_rv3", {31'h0, core.resp_valid}, 32'h0);
    txn(0, F3_W, 32'h40, 0, 2, 0, 32'hDEADBEEF, "lw_after_rst");
    chk("ram_word10", ram[16], 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
